// File: rtl/phase_meter.sv
// phase_meter: estimates the per-clock phase increment of an 8-bit truncated phase
// stream by unwrapping successive samples and averaging over 2^AVG_LOG2 differences.
module phase_meter #(
   parameter int WIDTH    = 14,
   parameter int AVG_LOG2 = 6
) (
   input  logic       clk,
   input  logic       clrn,
   input  logic [7:0] phase,
   input  logic       phase_vld,
   input  logic       start,
   output logic       busy,
   output logic       done,
   output logic [7:0] phinc_est,
   output logic       sat
);
   localparam int SUM_W = 8 + AVG_LOG2;
   localparam int SHIFT = AVG_LOG2 - (WIDTH - 8);
   localparam logic [AVG_LOG2-1:0] CNT_LAST = '1;
   localparam logic [AVG_LOG2-1:0] CNT_ONE  = AVG_LOG2'(1);
   localparam logic [SUM_W-1:0]    EST_MAX  = SUM_W'(255);

   typedef enum logic [1:0] {IDLE, PRIME, ACCUM} state_t;

   state_t              state_q, state_d;
   logic [SUM_W-1:0]    sum_q, sum_d;
   logic [AVG_LOG2-1:0] cnt_q, cnt_d;
   logic [7:0]          prev_q, prev_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic [7:0]          est_q, est_d;
   logic                sat_q, sat_d;

   logic [7:0]          diff;
   logic [SUM_W-1:0]    total;
   logic [SUM_W-1:0]    scaled;

   // Modulo-256 forward difference unwraps the 255->0 phase wrap as +1.
   assign diff   = phase - prev_q;
   assign total  = sum_q + SUM_W'(diff);
   assign scaled = total >> SHIFT;

   always_comb begin
      state_d = state_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      prev_d  = prev_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      est_d   = est_q;
      sat_d   = sat_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = PRIME;
               sum_d   = '0;
               cnt_d   = '0;
               busy_d  = 1'b1;
            end
         end
         PRIME: begin
            if (phase_vld) begin
               prev_d  = phase;
               state_d = ACCUM;
            end
         end
         ACCUM: begin
            if (phase_vld) begin
               prev_d = phase;
               sum_d  = total;
               cnt_d  = cnt_q + CNT_ONE;
               if (cnt_q == CNT_LAST) begin
                  est_d   = (scaled > EST_MAX) ? 8'hFF : scaled[7:0];
                  sat_d   = (scaled > EST_MAX);
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state_q <= IDLE;
         sum_q   <= '0;
         cnt_q   <= '0;
         prev_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         est_q   <= '0;
         sat_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         prev_q  <= prev_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         est_q   <= est_d;
         sat_q   <= sat_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign phinc_est = est_q;
   assign sat       = sat_q;

endmodule

// File: tb/tb_phase_meter.sv
// tb_phase_meter: drives phase_meter from a behavioural accumulator and checks
// estimates and done/busy timing against a sample-list reference model.
module tb_phase_meter;
   localparam int WIDTH    = 14;
   localparam int AVG_LOG2 = 6;
   localparam int N        = 1 << AVG_LOG2;
   localparam int SHIFT    = AVG_LOG2 - (WIDTH - 8);

   logic       clk = 1'b0;
   logic       clrn;
   logic [7:0] phase;
   logic       phase_vld;
   logic       start;
   logic       busy;
   logic       done;
   logic [7:0] phinc_est;
   logic       sat;

   int checks = 0;
   int errors = 0;
   logic [WIDTH-1:0] acc;
   int phincCur;
   int lastEst;
   int lastSat;

   typedef struct {
      string name;
      int    phinc;
      int    acc0;
      int    vldMode;
      int    startMode;
      int    expEst;
      int    expSat;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   phase_meter #(.WIDTH(WIDTH), .AVG_LOG2(AVG_LOG2)) dut (
      .clk       (clk),
      .clrn      (clrn),
      .phase     (phase),
      .phase_vld (phase_vld),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .phinc_est (phinc_est),
      .sat       (sat)
   );

   function automatic vec_t mkVec(input string name, input int phinc, input int acc0,
                                  input int vldMode, input int startMode,
                                  input int expEst, input int expSat);
      vec_t v;
      v.name      = name;
      v.phinc     = phinc;
      v.acc0      = acc0;
      v.vldMode   = vldMode;
      v.startMode = startMode;
      v.expEst    = expEst;
      v.expSat    = expSat;
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Drive one clock cycle from the falling edge; the accumulator free-runs every clock.
   task automatic applyStimulus(input logic s, input logic v);
      start     = s;
      phase_vld = v;
      phase     = acc[WIDTH-1 -: 8];
      @(posedge clk);
      acc = acc + phincCur[WIDTH-1:0];
      @(negedge clk);
   endtask

   task automatic runMeasurement(input vec_t v);
      int  samples[$];
      int  cyc;
      int  doneCount;
      int  total;
      int  modelEst;
      int  modelSat;
      bit  vld;
      bit  st;
      bit  expDone;

      phincCur  = v.phinc;
      acc       = v.acc0[WIDTH-1:0];
      applyStimulus(1'b1, 1'b1);
      checkOutput({v.name, " busy_rise"}, 32'(busy), 32'd1);
      doneCount = 0;
      cyc       = 0;
      while (doneCount == 0 && cyc < 1000) begin
         case (v.vldMode)
            0:       vld = 1'b1;
            1:       vld = (cyc % 2 == 0);
            default: vld = ($urandom_range(3) != 0);
         endcase
         st = 1'b0;
         if (v.startMode == 1 && cyc == 20) st = 1'b1;
         if (v.startMode == 2 && vld && samples.size() == N) st = 1'b1;
         if (vld) samples.push_back(int'(acc[WIDTH-1 -: 8]));
         applyStimulus(st, vld);
         expDone = vld && (samples.size() == N + 1);
         if (done === 1'b1) doneCount++;
         checkOutput({v.name, " done"}, 32'(done), 32'(expDone));
         checkOutput({v.name, " busy"}, 32'(busy), expDone ? 32'd0 : 32'd1);
         if (!expDone) begin
            checkOutput({v.name, " est_hold"}, 32'(phinc_est), 32'(lastEst));
            checkOutput({v.name, " sat_hold"}, 32'(sat), 32'(lastSat));
         end
         cyc++;
      end
      if (doneCount == 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s timeout: got no done within %0d cycles, expected one", v.name, cyc);
      end

      total = 0;
      for (int i = 1; i <= N && i < samples.size(); i++)
         total += (samples[i] - samples[i-1]) & 255;
      modelEst = total >>> SHIFT;
      modelSat = (modelEst > 255) ? 1 : 0;
      if (modelEst > 255) modelEst = 255;
      checkOutput({v.name, " est_model"}, 32'(phinc_est), 32'(modelEst));
      checkOutput({v.name, " sat_model"}, 32'(sat), 32'(modelSat));
      if (v.expEst >= 0) begin
         checkOutput({v.name, " est_expected"}, 32'(phinc_est), 32'(v.expEst));
         checkOutput({v.name, " sat_expected"}, 32'(sat), 32'(v.expSat));
      end
      lastEst = modelEst;
      lastSat = modelSat;

      // A start coinciding with the final sample must not launch a new run.
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b0, 1'b1);
         checkOutput({v.name, " post_done"}, 32'(done), 32'd0);
         checkOutput({v.name, " post_busy"}, 32'(busy), 32'd0);
      end
   endtask

   initial begin
      clrn      = 1'b0;
      start     = 1'b0;
      phase_vld = 1'b0;
      phase     = 8'd0;
      acc       = '0;
      phincCur  = 0;
      lastEst   = 0;
      lastSat   = 0;

      vecs.push_back(mkVec("phinc64",       64,    0,     0, 0, 64,  0));
      vecs.push_back(mkVec("phinc100_wrap", 100,   12345, 0, 0, 100, 0));
      vecs.push_back(mkVec("toggle_vld",    100,   777,   1, 0, 200, 0));
      vecs.push_back(mkVec("restart_mid",   64,    500,   0, 1, 64,  0));
      vecs.push_back(mkVec("start_on_last", 100,   3000,  0, 2, 100, 0));
      for (int r = 0; r < 4; r++)
         vecs.push_back(mkVec($sformatf("random%0d", r), int'($urandom_range(1, 600)),
                              int'($urandom_range(0, 16383)), 2, 0, -1, 0));
      vecs.push_back(mkVec("step5_sat",     320,   0,     0, 0, 255, 1));

      repeat (3) @(negedge clk);
      checkOutput("reset busy", 32'(busy), 32'd0);
      checkOutput("reset done", 32'(done), 32'd0);
      checkOutput("reset est",  32'(phinc_est), 32'd0);
      checkOutput("reset sat",  32'(sat), 32'd0);
      clrn = 1'b1;
      applyStimulus(1'b0, 1'b0);

      for (int i = 0; i < vecs.size(); i++) begin
         $display("[TB] running %s", vecs[i].name);
         runMeasurement(vecs[i]);
      end

      $display("[TB] running mid_accum_reset");
      phincCur = 64;
      acc      = '0;
      applyStimulus(1'b1, 1'b1);
      repeat (20) applyStimulus(1'b0, 1'b1);
      clrn = 1'b0;
      #1;
      checkOutput("midreset busy", 32'(busy), 32'd0);
      checkOutput("midreset done", 32'(done), 32'd0);
      checkOutput("midreset est",  32'(phinc_est), 32'd0);
      checkOutput("midreset sat",  32'(sat), 32'd0);
      applyStimulus(1'b0, 1'b1);
      applyStimulus(1'b0, 1'b1);
      clrn    = 1'b1;
      lastEst = 0;
      lastSat = 0;
      for (int k = 0; k < 10; k++) begin
         applyStimulus(1'b0, 1'b1);
         checkOutput("idle_after_reset busy", 32'(busy), 32'd0);
         checkOutput("idle_after_reset done", 32'(done), 32'd0);
      end
      runMeasurement(mkVec("after_reset", 64, 0, 0, 0, 64, 0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
